// File: rtl/fp_posit_acc.sv
// Dot-product accumulator fed by fp_posit_mul: aligns each signed product into a
// Q24.16 two's-complement sum, closes a batch every len_q products, saturates on overflow.
module fp_posit_acc #(
    parameter int EXP_WIDTH = 5,
    parameter int MAN_WIDTH = 14,
    parameter int MAN_FRAC  = 12,
    parameter int ACC_WIDTH = 40,
    parameter int ACC_FRAC  = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic [LEN_WIDTH-1:0] acc_len,
    input  logic                 sign_in,
    input  logic [EXP_WIDTH-1:0] exp_in,
    input  logic [MAN_WIDTH-1:0] mantissa_in,
    input  logic                 start_acc,
    input  logic                 mul_done,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    output logic                 acc_ovf,
    output logic                 busy,
    output logic                 dbg_state_o
);

    // Handshake: a product is consumed on any rising edge where mul_done=1, the
    // FSM is in RUN and set=0; there is no back-pressure. acc_valid is a one-cycle
    // strobe qualifying acc_out/acc_ovf, which hold until the next completion.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int SH_W = EXP_WIDTH + 2;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt_q;

    logic                   s1_valid_q;
    logic [ACC_WIDTH-1:0]   s1_term_q;
    logic                   s1_first_q;
    logic                   s1_last_q;

    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   ovf_q;
    logic [ACC_WIDTH-1:0]   acc_out_q;
    logic                   acc_valid_q;
    logic                   acc_ovf_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (set) begin
            state_d = (acc_len != '0) ? S_RUN : S_IDLE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy        = (state_q == S_RUN) && (cnt_q != '0);
        dbg_state_o = state_q;
    end

    // ---------------- Stage 1: align product, track batch position ----------------
    logic signed [SH_W-1:0] sh;
    logic [SH_W-1:0]        sh_abs;
    logic [ACC_WIDTH-1:0]   man_ext;
    logic [ACC_WIDTH-1:0]   mag;
    logic [ACC_WIDTH-1:0]   term;
    logic                   first;
    logic                   last;
    logic [LEN_WIDTH-1:0]   pos;
    logic                   take;

    always_comb begin
        sh      = $signed(exp_in) + $signed(SH_W'(ACC_FRAC - MAN_FRAC));
        sh_abs  = sh[SH_W-1] ? SH_W'(-sh) : SH_W'(sh);
        man_ext = {{(ACC_WIDTH-MAN_WIDTH){1'b0}}, mantissa_in};
        // Right shifts drop fraction bits below the accumulator LSB (truncation).
        mag     = sh[SH_W-1] ? (man_ext >> sh_abs) : (man_ext << sh_abs);
        term    = sign_in ? (~mag + 1'b1) : mag;
        first   = start_acc | (cnt_q == '0);
        pos     = first ? LEN_WIDTH'(1) : (cnt_q + 1'b1);
        last    = (pos == len_q);
        take    = (state_q == S_RUN) && mul_done && !set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_term_q  <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (set) begin
            len_q      <= acc_len;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= take;
            if (take) begin
                s1_term_q  <= term;
                s1_first_q <= first;
                s1_last_q  <= last;
                cnt_q      <= last ? '0 : pos;
            end
        end
    end

    // ---------------- Stage 2: saturating accumulate ----------------
    logic [ACC_WIDTH:0]   sum_w;
    logic                 sat;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 ovf_new;

    always_comb begin
        if (s1_first_q) begin
            sum_w = {s1_term_q[ACC_WIDTH-1], s1_term_q};
        end else begin
            sum_w = {acc_q[ACC_WIDTH-1], acc_q} + {s1_term_q[ACC_WIDTH-1], s1_term_q};
        end
        // One guard bit: disagreement with the sign bit means the true sum left range.
        sat     = sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1];
        sum_sat = sat ? (sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_w[ACC_WIDTH-1:0];
        ovf_new = s1_first_q ? sat : (ovf_q | sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_ovf_q   <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            if (set) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (s1_valid_q) begin
                acc_q <= sum_sat;
                ovf_q <= ovf_new;
                if (s1_last_q) begin
                    acc_out_q   <= sum_sat;
                    acc_ovf_q   <= ovf_new;
                    acc_valid_q <= 1'b1;
                end
            end
        end
    end

    assign acc_out   = acc_out_q;
    assign acc_valid = acc_valid_q;
    assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_fp_posit_acc.sv
// Bench for fp_posit_acc: behavioural batch model feeds an expected-result queue,
// a negedge monitor pops and compares on every acc_valid.
module tb_fp_posit_acc;

  localparam int EW = 5;
  localparam int MW = 14;
  localparam int AW = 40;
  localparam int LW = 8;
  localparam longint SMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (AW - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic set;
  logic [LW-1:0] acc_len;
  logic sign_in;
  logic [EW-1:0] exp_in;
  logic [MW-1:0] mantissa_in;
  logic start_acc;
  logic mul_done;
  logic [AW-1:0] acc_out;
  logic acc_valid;
  logic acc_ovf;
  logic busy;
  logic dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fp_posit_acc dut (
    .clk         (clk),
    .rst         (rst),
    .set         (set),
    .acc_len     (acc_len),
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .mantissa_in (mantissa_in),
    .start_acc   (start_acc),
    .mul_done    (mul_done),
    .acc_out     (acc_out),
    .acc_valid   (acc_valid),
    .acc_ovf     (acc_ovf),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  logic exp_ovf_q[$];
  int exp_cyc_q[$];

  always @(negedge clk) begin : monitor
    logic [AW-1:0] ea;
    logic eo;
    int ec;
    if (!rst && acc_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(acc_valid), 64'd0);
      end else begin
        ea = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("acc_out", 64'(acc_out), 64'(ea));
        check("acc_ovf", 64'(acc_ovf), 64'(eo));
        check("latency", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- reference model ----------------
  int m_len;
  int m_cnt;
  longint m_acc;
  bit m_ovf;
  bit m_run;

  function automatic longint term_of(input bit s, input int e, input int m);
    int sh;
    longint mag;
    sh = e + 4;
    mag = (sh >= 0) ? (longint'(m) <<< sh) : (longint'(m) >>> (-sh));
    return s ? -mag : mag;
  endfunction

  task automatic model_step(input bit s, input int e, input int m, input bit st);
    bit first;
    bit last;
    bit sat;
    int n;
    longint t;
    longint sum;
    if (!m_run) return;
    t = term_of(s, e, m);
    first = st || (m_cnt == 0);
    n = first ? 1 : m_cnt + 1;
    last = (n == m_len);
    m_cnt = last ? 0 : n;
    sum = first ? t : m_acc + t;
    sat = 1'b0;
    if (sum > SMAX) begin sum = SMAX; sat = 1'b1; end
    if (sum < SMIN) begin sum = SMIN; sat = 1'b1; end
    m_ovf = first ? sat : (m_ovf | sat);
    m_acc = sum;
    if (last) begin
      exp_q.push_back(m_acc[AW-1:0]);
      exp_ovf_q.push_back(m_ovf);
      exp_cyc_q.push_back(cyc + 2);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_prod(input bit s, input int e, input int m, input bit st);
    sign_in = s;
    exp_in = e[EW-1:0];
    mantissa_in = m[MW-1:0];
    start_acc = st;
    mul_done = 1'b1;
    model_step(s, e, m, st);
    @(posedge clk);
    #1;
    mul_done = 1'b0;
    start_acc = 1'b0;
  endtask

  task automatic do_set(input int len, input bit with_prod);
    set = 1'b1;
    acc_len = len[LW-1:0];
    if (with_prod) begin
      sign_in = 1'b0;
      exp_in = '0;
      mantissa_in = 14'h1000;
      mul_done = 1'b1;
    end
    @(posedge clk);
    #1;
    set = 1'b0;
    mul_done = 1'b0;
    m_len = len;
    m_cnt = 0;
    m_acc = 0;
    m_ovf = 1'b0;
    m_run = (len != 0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_len = 0;
    m_cnt = 0;
    m_acc = 0;
    m_ovf = 1'b0;
    m_run = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    set = 1'b0;
    acc_len = '0;
    sign_in = 1'b0;
    exp_in = '0;
    mantissa_in = '0;
    start_acc = 1'b0;
    mul_done = 1'b0;
    m_len = 0; m_cnt = 0; m_acc = 0; m_ovf = 1'b0; m_run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_out", 64'(acc_out), 64'd0);
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_acc_ovf", 64'(acc_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    idle(1);

    // IDLE ignores products before any set
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    check("idle_busy", 64'(busy), 64'd0);
    idle(3);

    // four 1.0 products -> 4.0
    do_set(4, 1'b0);
    check("run_state", 64'(dbg_state), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive_prod(1'b0, 0, 'h1000, 1'b0);
      if (i == 1) check("busy_mid", 64'(busy), 64'd1);
    end
    check("busy_after_last", 64'(busy), 64'd0);
    idle(4);

    // 1.5 - 0.25 = 1.25
    do_set(2, 1'b0);
    drive_prod(1'b0, 0, 'h1800, 1'b0);
    drive_prod(1'b1, -2, 'h1000, 1'b0);
    idle(4);

    // truncation of tiny terms: 1 + 0 - 1
    do_set(3, 1'b0);
    drive_prod(1'b0, -16, 'h1000, 1'b0);
    drive_prod(1'b0, -16, 'h0FFF, 1'b0);
    drive_prod(1'b1, -16, 'h1FFF, 1'b0);
    idle(4);

    // positive saturation, then a clean batch at the same length
    do_set(70, 1'b0);
    for (int i = 0; i < 70; i++) drive_prod(1'b0, 15, 'h3FFF, 1'b0);
    idle(4);
    for (int i = 0; i < 70; i++) drive_prod(1'b0, 0, 'h1000, 1'b0);
    idle(4);

    // set mid-batch restarts with the new length
    do_set(4, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    idle(2);
    do_set(2, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    idle(4);

    // reset mid-batch: products ignored until the next set
    do_set(4, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    idle(2);
    do_rst();
    check("post_rst_acc_out", 64'(acc_out), 64'd0);
    for (int i = 0; i < 4; i++) drive_prod(1'b0, 0, 'h1000, 1'b0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_state", 64'(dbg_state), 64'd0);
    idle(4);

    // start_acc abandons the partial sum: 4 x 0.5 = 2.0
    do_set(4, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    drive_prod(1'b0, -1, 'h1000, 1'b1);
    for (int i = 0; i < 3; i++) drive_prod(1'b0, -1, 'h1000, 1'b0);
    idle(4);

    // set with a same-cycle product drops it; len 1 completes on every term
    do_set(1, 1'b1);
    idle(3);
    drive_prod(1'b1, 3, 'h2A5C, 1'b0);
    drive_prod(1'b0, -7, 'h3FFF, 1'b0);
    drive_prod(1'b1, 15, 'h3FFF, 1'b0);
    drive_prod(1'b0, 0, 'h0000, 1'b0);
    drive_prod(1'b1, 0, 'h0000, 1'b0);
    idle(4);

    // length 0 disables the block
    do_set(0, 1'b0);
    check("len0_state", 64'(dbg_state), 64'd0);
    drive_prod(1'b0, 0, 'h1000, 1'b0);
    idle(4);

    // negative saturation
    do_set(70, 1'b0);
    for (int i = 0; i < 70; i++) drive_prod(1'b1, 15, 'h3FFF, 1'b0);
    idle(4);

    // random batches, back-to-back with occasional gaps and restarts
    for (int r = 0; r < 5; r++) begin
      do_set($urandom_range(1, 6), 1'b0);
      for (int k = 0; k < 25; k++) begin
        drive_prod(1'($urandom_range(0, 1)), $urandom_range(0, 31) - 16,
                   $urandom_range(0, 'h3FFF), ($urandom_range(0, 7) == 0));
        check("busy_rand", 64'(busy), 64'(m_run && (m_cnt != 0)));
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(4);
    end

    idle(5);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
